// File: rtl/bcd_to_bin.sv
// Iterative packed-BCD to binary converter: one digit per clock, MS digit first (acc = acc*10 + digit).
// Optional leading-zero skip when BCD_TO_BIN_LZSKIP_EN is defined (same results, shorter latency).
module bcd_to_bin #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 32,
  localparam int CNT_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [BIN_W-1:0]        bin_out,
  output logic                    err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                         state;
  logic [NUM_DIGITS-1:0][3:0]     opnd;
  logic [BIN_W-1:0]               acc;
  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_start;
  logic [3:0]                     cur_dig;
  logic [BIN_W-1:0]               acc_nxt;

  assign cur_dig = opnd[cnt];
  // x*10 as x*8 + x*2; wraps mod 2^BIN_W by construction
  assign acc_nxt = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, cur_dig};

`ifdef BCD_TO_BIN_LZSKIP_EN
  logic [NUM_DIGITS-1:0][3:0] in_dig;
  assign in_dig = bcd_in;
  // Highest nonzero digit wins; all-zero falls back to index 0 (one CONV cycle)
  always_comb begin
    cnt_start = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (in_dig[i] != 4'd0) cnt_start = CNT_W'(i);
  end
`else
  assign cnt_start = CNT_W'(NUM_DIGITS - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      opnd      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opnd     <= bcd_in;
            acc      <= '0;
            err      <= 1'b0;
            cnt      <= cnt_start;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          acc <= acc_nxt;
          if (cur_dig > 4'd9) err <= 1'b1;
          if (cnt == '0) begin
            bin_out   <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Scoreboard bench for bcd_to_bin: expected result/err/latency queued on accept, checked on out_valid rise.
module tb_bcd_to_bin;
  localparam int ND = 8;
  localparam int BW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*ND-1:0] bcd_in = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BW-1:0]   bin_out;
  logic            err;
  logic            out_valid;
  logic            out_ready = 1'b1;

  bcd_to_bin #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
    .bin_out(bin_out), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] bin;
    logic          err;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic ov_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] m_bin(input logic [4*ND-1:0] op);
    logic [BW-1:0] a = '0;
    for (int i = ND-1; i >= 0; i--) a = a * 10 + BW'(op[4*i +: 4]);
    return a;
  endfunction

  function automatic logic m_err(input logic [4*ND-1:0] op);
    logic e = 1'b0;
    for (int i = 0; i < ND; i++) if (op[4*i +: 4] > 4'd9) e = 1'b1;
    return e;
  endfunction

  function automatic int m_lat(input logic [4*ND-1:0] op);
`ifdef BCD_TO_BIN_LZSKIP_EN
    int l = 1;
    for (int i = 0; i < ND; i++) if (op[4*i +: 4] != 4'd0) l = i + 1;
    return l;
`else
    return ND;
`endif
  endfunction

  // Monitor: one scoreboard entry per rising out_valid
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_q) begin
      if (sb.size() == 0) chk("unexpected_out", out_valid, 1'b0);
      else begin
        chk("bin", bin_out, sb[0].bin);
        chk("err", err, sb[0].err);
        chk("lat", cyc - sb[0].acc_cyc, sb[0].lat);
        void'(sb.pop_front());
      end
    end
    ov_q <= out_valid;
  end

  task automatic send(input logic [4*ND-1:0] op, input logic [BW-1:0] eb, input logic ee);
    exp_t e;
    bit   ok = 1'b0;
    @(negedge clk);
    bcd_in   = op;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", ok, 1'b1);
    if (ok) begin
      @(posedge clk);
      #1;
      e.bin = eb; e.err = ee; e.lat = m_lat(op); e.acc_cyc = cyc;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    bcd_in   = 32'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [4*ND-1:0] op;
    logic [BW-1:0]   hold_bin;
    logic            hold_err;
    bit              seen;

    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bin", bin_out, 0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    send(32'h12345678, 32'h00BC614E, 1'b0);
    send(32'h99999999, 32'h05F5E0FF, 1'b0);
    send(32'h00000000, 32'd0, 1'b0);
    send(32'h0000001A, 32'd20, 1'b1);
    send(32'h00000042, 32'd42, 1'b0);
    send(32'h00000007, 32'd7, 1'b0);
    send(32'h00010000, 32'd10000, 1'b0);
    send(32'hF0000000, 32'd150000000 * 10 / 10, 1'b1);
    for (int i = 0; i < 6; i++) begin
      op = 32'($urandom);
      if (i % 2 == 0) op = op & 32'h77777777;
      send(op, m_bin(op), m_err(op));
    end
    drain();

    // Backpressure: result and err held, new input ignored while in DONE
    out_ready = 1'b0;
    send(32'h0000001A, 32'd20, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("bp_out_valid", seen, 1'b1);
    hold_bin = bin_out;
    hold_err = err;
    bcd_in   = 32'h00000042;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_bin", bin_out, 32'd20);
      chk("bp_err", err, hold_err);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_valid", out_valid, 1'b0);
    chk("bp_bin_kept", bin_out, hold_bin);
    drain();

    // Async reset mid-conversion discards the operand
    send(32'h12345678, 32'h00BC614E, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h00000099, 32'd99, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
